alu_seq_ctrl: RTL
=================

Name: alu_seq_ctrl

Overview:
- Sequencing controller for the 8-bit ALU. Accepts one operation request at a time over a valid/ready handshake.
- Registers the request's operands. Drives the ALU select and operand lines, and iterates single-bit ALU shifts for multi-bit shift amounts.
- Owns the architectural carry flag. Returns result, carry and error over a response handshake with backpressure.
- Sits between the instruction decode/issue stage and the ALU datapath.

Parameters:
- DW, 8, datapath width (ALU operand/result width).
- SAW, 3, shift-amount width; max shift is 2**SAW-1.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  controller can accept a request.
- op_i  in  4  opcode.
- opa_i  in  DW  operand A.
- opb_i  in  DW  operand B.
- shamt_i  in  SAW  shift amount (SHL/SHR only).
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  consumer accepts response.
- rsp_result_o  out  DW  operation result.
- rsp_cf_o  out  1  carry flag after the operation.
- rsp_err_o  out  1  illegal opcode.
- oprnd_0_o  out  DW  to ALU operand 0.
- oprnd_1_o  out  DW  to ALU operand 1.
- cf_sel_o  out  1  ALU carry-in = 1 when high.
- alu_sel_0_o  out  1  ALU arithmetic(0)/logic(1) group select.
- alu_sel_1_o  out  2  ALU function select within the group.
- inv_sel_o  out  1  ALU inverts operand 1.
- shftr_sel_o  out  1  ALU 1-bit right shift of operand 0.
- shftl_sel_o  out  1  ALU 1-bit left shift of operand 0.
- alu_result_i  in  DW  from ALU result.
- cf_i  in  1  from ALU carry out / shifted-out bit.

Behaviour:
- Reset (rst_n_i low, async):
  - State IDLE.
  - All outputs 0, except req_ready_o = 1 once reset deasserts.
  - Carry flag cf_q = 0; operand and result registers = 0.
  - Reset mid-operation aborts it; no response is issued.
- Opcodes (select encoding; unlisted selects = 0):
  - 0 NOP: result = opa, no ALU cycle needed but still takes EXEC.
  - 1 ADD: sel0 = 0, sel1 = 00.
  - 2 ADC: ADD with cf_sel = cf_q.
  - 3 SUB: sel1 = 00, inv = 1, cf_sel = 1 (A + ~B + 1; cf = no-borrow).
  - 4 AND: sel0 = 1, sel1 = 00.
  - 5 OR: sel0 = 1, sel1 = 01.
  - 6 XOR: sel0 = 1, sel1 = 10.
  - 7 NOT: sel0 = 1, sel1 = 11.
  - 8 SHL: shftl = 1.
  - 9 SHR: shftr = 1.
  - 15 CLC: cf_q cleared, result = 0.
  - 10–14 illegal.
- Carry flag: cf_q updates from cf_i only on ADD/ADC/SUB and on each shift step; otherwise it is unchanged.
- FSM IDLE -> EXEC -> RESP -> IDLE:
  - IDLE: req_ready_o = 1. On req_valid_i & req_ready_o, register op/opa/opb/shamt into op_q/a_q/b_q/cnt_q, then go to EXEC. ALU selects are 0 in IDLE and RESP.
  - EXEC: oprnd_0_o = a_q, oprnd_1_o = b_q. Selects are decoded combinationally from op_q. alu_result_i/cf_i are sampled at the end of the cycle.
    - Non-shift ops: 1 EXEC cycle, then RESP.
    - SHL/SHR: each EXEC cycle loads a_q <= alu_result_i and cf_q <= cf_i, and decrements cnt_q. The FSM stays in EXEC while cnt_q > 1.
    - shamt = 0: no ALU shift is driven (selects 0), result = opa, cf unchanged, 1 EXEC cycle.
    - Illegal or CLC: EXEC selects are 0.
  - RESP: rsp_valid_o = 1, holding result/cf/err stable until rsp_ready_i. Return to IDLE on rsp_ready_i.
- Latency: request accepted at cycle N -> rsp_valid_o at N+2 (non-shift); N+1+max(shamt,1) for shifts.
- req_ready_o = 0 outside IDLE; there is no pipelining and a single request is outstanding.
- Illegal opcode: rsp_err_o = 1, result 0, cf_q unchanged.
- All arithmetic is modulo 2**DW; carry exits only via cf_i.

Test Plan:
- ADD 0xF0 + 0x20 -> rsp at N+2, result 0x10, cf 1. Then ADC 0x01 + 0x01 -> result 0x03, cf 0.
- SUB 0x05 - 0x07 -> inv_sel = cf_sel = 1 in EXEC; result 0xFE, cf 0. SUB 0x07 - 0x05 -> result 0x02, cf 1.
- SHL opa = 0x81, shamt = 3 -> 3 EXEC cycles with shftl_sel_o high; result 0x08, cf 0 (last bit out). shamt = 0 -> result 0x81, cf unchanged, rsp at N+2.
- Backpressure: hold rsp_ready_i low 4 cycles -> rsp_valid_o and data stable, req_ready_o = 0. Req_valid_i during this time is not accepted.
- Illegal op 12 -> rsp_err_o = 1, result 0, cf unchanged. CLC after cf = 1 -> cf 0.
- Assert rst_n_i low mid-SHR (shamt = 7, cycle 3) -> outputs immediately 0, no response, cf_q = 0. Next request processes normally.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: sequencing controller sitting between issue and the 8-bit ALU.
// Takes one request at a time, drives the ALU select/operand lines, repeats
// single-bit ALU shifts for multi-bit shift amounts, owns the architectural
// carry flag and returns result/carry/error over a response handshake.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a request; operands registered on accept
// EXEC  | ALU driven from a_q/b_q; shifts stay here while cnt_q > 1
// RESP  | response valid, held stable until the consumer takes it
module alu_seq_ctrl #(
    parameter int DW  = 8,
    parameter int SAW = 3
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    input  logic           req_valid_i,
    output logic           req_ready_o,
    input  logic [3:0]     op_i,
    input  logic [DW-1:0]  opa_i,
    input  logic [DW-1:0]  opb_i,
    input  logic [SAW-1:0] shamt_i,
    output logic           rsp_valid_o,
    input  logic           rsp_ready_i,
    output logic [DW-1:0]  rsp_result_o,
    output logic           rsp_cf_o,
    output logic           rsp_err_o,
    output logic [DW-1:0]  oprnd_0_o,
    output logic [DW-1:0]  oprnd_1_o,
    output logic           cf_sel_o,
    output logic           alu_sel_0_o,
    output logic [1:0]     alu_sel_1_o,
    output logic           inv_sel_o,
    output logic           shftr_sel_o,
    output logic           shftl_sel_o,
    input  logic [DW-1:0]  alu_result_i,
    input  logic           cf_i
);

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_ADC = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;
    localparam logic [3:0] OP_CLC = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [3:0]     op_q;
    logic [DW-1:0]  a_q;
    logic [DW-1:0]  b_q;
    logic [SAW-1:0] cnt_q;
    logic           cf_q;
    logic [DW-1:0]  result_q;
    logic           err_q;
    logic           is_shift;

    assign is_shift = (op_q == OP_SHL) || (op_q == OP_SHR);

    // Response payload comes straight from registers so it is stable in RESP.
    assign rsp_result_o = result_q;
    assign rsp_cf_o     = cf_q;
    assign rsp_err_o    = err_q;

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic, handshake outputs and ALU select decode.
    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        oprnd_0_o   = '0;
        oprnd_1_o   = '0;
        cf_sel_o    = 1'b0;
        alu_sel_0_o = 1'b0;
        alu_sel_1_o = 2'b00;
        inv_sel_o   = 1'b0;
        shftr_sel_o = 1'b0;
        shftl_sel_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Ready is held low while reset is asserted.
                req_ready_o = rst_n_i;
                if (req_valid_i && rst_n_i) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                oprnd_0_o = a_q;
                oprnd_1_o = b_q;
                case (op_q)
                    OP_ADD: begin
                    end
                    OP_ADC: cf_sel_o = cf_q;
                    OP_SUB: begin
                        inv_sel_o = 1'b1;
                        cf_sel_o  = 1'b1;
                    end
                    OP_AND: alu_sel_0_o = 1'b1;
                    OP_OR: begin
                        alu_sel_0_o = 1'b1;
                        alu_sel_1_o = 2'b01;
                    end
                    OP_XOR: begin
                        alu_sel_0_o = 1'b1;
                        alu_sel_1_o = 2'b10;
                    end
                    OP_NOT: begin
                        alu_sel_0_o = 1'b1;
                        alu_sel_1_o = 2'b11;
                    end
                    // A zero shift amount passes opa through untouched.
                    OP_SHL: shftl_sel_o = (cnt_q != '0);
                    OP_SHR: shftr_sel_o = (cnt_q != '0);
                    default: begin
                    end
                endcase
                if (!(is_shift && (cnt_q > SAW'(1)))) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Operand capture, shift iteration, carry flag and response registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            cf_q     <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        op_q  <= op_i;
                        a_q   <= opa_i;
                        b_q   <= opb_i;
                        cnt_q <= shamt_i;
                        err_q <= 1'b0;
                    end
                end
                S_EXEC: begin
                    case (op_q)
                        OP_NOP: result_q <= a_q;
                        OP_ADD, OP_ADC, OP_SUB: begin
                            result_q <= alu_result_i;
                            cf_q     <= cf_i;
                        end
                        OP_AND, OP_OR, OP_XOR, OP_NOT: result_q <= alu_result_i;
                        OP_SHL, OP_SHR: begin
                            if (cnt_q == '0) begin
                                result_q <= a_q;
                            end else begin
                                // Feed each 1-bit shift back as the next operand.
                                a_q      <= alu_result_i;
                                cf_q     <= cf_i;
                                cnt_q    <= cnt_q - SAW'(1);
                                result_q <= alu_result_i;
                            end
                        end
                        OP_CLC: begin
                            cf_q     <= 1'b0;
                            result_q <= '0;
                        end
                        default: begin
                            result_q <= '0;
                            err_q    <= 1'b1;
                        end
                    endcase
                end
                default: begin
                end
            endcase
        end
    end

endmodule
